extensor_signo: RTL and testbench

EXTENSOR_SIGNO -- requirements
Module: extensor_signo

---
 rtl/extensor_signo.sv | 47 ++++
 tb/tb_extensor_signo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/extensor_signo.sv
// Immediate generator for RISC-V instruction words.
// Decodes the immediate field of COD according to ext_sel and registers the
// 32-bit result on IMM with one cycle of latency.
module extensor_signo (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] COD,
  input  logic [3:0]  ext_sel,
  output logic [31:0] IMM
);

  localparam logic [3:0] SEL_I     = 4'd0;
  localparam logic [3:0] SEL_S     = 4'd1;
  localparam logic [3:0] SEL_B     = 4'd2;
  localparam logic [3:0] SEL_U     = 4'd3;
  localparam logic [3:0] SEL_J     = 4'd4;
  localparam logic [3:0] SEL_SHAMT = 4'd5;

  logic        sign;
  logic [31:0] imm_next;

  assign sign = COD[31];

  // Select and extend the immediate field; unused selects yield zero.
  always_comb begin
    imm_next = 32'h0000_0000;
    case (ext_sel)
      SEL_I:     imm_next = {{20{sign}}, COD[31:20]};
      SEL_S:     imm_next = {{20{sign}}, COD[31:25], COD[11:7]};
      SEL_B:     imm_next = {{19{sign}}, COD[31], COD[7], COD[30:25], COD[11:8], 1'b0};
      SEL_U:     imm_next = {COD[31:12], 12'h000};
      SEL_J:     imm_next = {{11{sign}}, COD[31], COD[19:12], COD[20], COD[30:21], 1'b0};
      SEL_SHAMT: imm_next = {27'd0, COD[24:20]};
      default:   imm_next = 32'h0000_0000;
    endcase
  end

  // Output register; reset wins over the normal update.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      IMM <= 32'h0000_0000;
    end else begin
      IMM <= imm_next;
    end
  end

endmodule

// File: tb/tb_extensor_signo.sv
// Scoreboard bench for extensor_signo: the driver pushes expected IMM values
// computed by an arithmetic reference model; a monitor pops and compares
// after each rising edge.
module tb_extensor_signo;

  logic        clock;
  logic        reset_n;
  logic [31:0] COD;
  logic [3:0]  ext_sel;
  logic [31:0] IMM;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  sel_q[$];
  logic [31:0] prev_exp;
  bit          prev_valid = 0;
  bit          done = 0;

  extensor_signo dut (
    .clock   (clock),
    .reset_n (reset_n),
    .COD     (COD),
    .ext_sel (ext_sel),
    .IMM     (IMM)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Two's-complement sign extension of a w-bit field, by arithmetic.
  function automatic logic [31:0] sext(input longint field, input int w);
    longint v;
    v = field;
    if (v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] cod, input logic [3:0] sel);
    longint c;
    longint f;
    c = longint'(cod);
    case (sel)
      4'd0: return sext((c >> 20) & 'hFFF, 12);
      4'd1: begin
        f = (((c >> 25) & 'h7F) << 5) | ((c >> 7) & 'h1F);
        return sext(f, 12);
      end
      4'd2: begin
        f = (((c >> 31) & 1) << 12) | (((c >> 7) & 1) << 11)
          | (((c >> 25) & 'h3F) << 5) | (((c >> 8) & 'hF) << 1);
        return sext(f, 13);
      end
      4'd3: begin
        f = (c >> 12) * 4096;
        return f[31:0];
      end
      4'd4: begin
        f = (((c >> 31) & 1) << 20) | (((c >> 12) & 'hFF) << 12)
          | (((c >> 20) & 1) << 11) | (((c >> 21) & 'h3FF) << 1);
        return sext(f, 21);
      end
      4'd5: begin
        f = (c >> 20) % 32;
        return f[31:0];
      end
      default: return 32'h0000_0000;
    endcase
  endfunction

  // One cycle of stimulus. When glitch is set, a first input pair is applied
  // and then replaced before the edge; only the final pair may show on IMM.
  task automatic drive(input logic rst, input logic [31:0] cod, input logic [3:0] sel,
                       input bit glitch, input logic [31:0] cod0, input logic [3:0] sel0);
    logic [31:0] e;
    @(negedge clock);
    if (prev_valid) begin
      checks++;
      if (IMM !== prev_exp) begin
        failures++;
        $display("FAIL hold_mid_cycle: IMM=%08h expected=%08h", IMM, prev_exp);
      end
    end
    reset_n = ~rst;
    if (glitch) begin
      COD = cod0;
      ext_sel = sel0;
      #2;
      if (prev_valid) begin
        checks++;
        if (IMM !== prev_exp) begin
          failures++;
          $display("FAIL input_change_latency: IMM=%08h expected=%08h", IMM, prev_exp);
        end
      end
    end
    COD = cod;
    ext_sel = sel;
    e = rst ? 32'h0000_0000 : ref_imm(cod, sel);
    exp_q.push_back(e);
    sel_q.push_back(rst ? 4'hF : sel);
    prev_exp = e;
    prev_valid = 1;
  endtask

  task automatic drive_plain(input logic rst, input logic [31:0] cod, input logic [3:0] sel);
    drive(rst, cod, sel, 0, 32'h0, 4'h0);
  endtask

  // Monitor: one registered result per rising edge once stimulus is queued.
  always begin
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) begin
      logic [31:0] e;
      logic [3:0]  s;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      checks++;
      if (IMM !== e) begin
        failures++;
        $display("FAIL imm_sel%0d: IMM=%08h expected=%08h", s, IMM, e);
      end
    end
  end

  // Fixed vectors: known-answer checks against literal constants.
  task automatic known(input logic [31:0] cod, input logic [3:0] sel, input logic [31:0] want);
    drive_plain(0, cod, sel);
    @(posedge clock);
    #2;
    checks++;
    if (IMM !== want) begin
      failures++;
      $display("FAIL known_sel%0d_cod%08h: IMM=%08h expected=%08h", sel, cod, IMM, want);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    COD = 32'hFFFF_FFFF;
    ext_sel = 4'd0;

    drive_plain(1, 32'hFFFF_FFFF, 4'd0);
    drive_plain(1, 32'h47FF_FFFF, 4'd3);

    known(32'h47FF_FFFF, 4'd0, 32'h0000_047F);
    known(32'h47FF_FFFF, 4'd1, 32'h0000_047F);
    known(32'h47FF_FFFF, 4'd2, 32'h0000_0C7E);
    known(32'h47FF_FFFF, 4'd3, 32'h47FF_F000);
    known(32'h47FF_FFFF, 4'd4, 32'h000F_FC7E);
    known(32'h47FF_FFFF, 4'd5, 32'h0000_001F);
    known(32'h47FF_FFFF, 4'd14, 32'h0000_0000);
    known(32'hFFF0_0093, 4'd0, 32'hFFFF_FFFF);
    known(32'h8000_0000, 4'd4, 32'hFFF0_0000);
    known(32'h8000_0000, 4'd1, 32'hFFFF_F800);
    known(32'h8000_0000, 4'd2, 32'hFFFF_F000);

    // Reset mid-operation, then release reloads the computed value.
    drive_plain(0, 32'hFFF0_0093, 4'd0);
    drive_plain(1, 32'hFFF0_0093, 4'd0);
    drive_plain(0, 32'hFFF0_0093, 4'd0);

    // Inputs changed between edges must not leak through early.
    drive(0, 32'h47FF_FFFF, 4'd3, 1, 32'h47FF_FFFF, 4'd0);
    drive(0, 32'h8000_0000, 4'd4, 1, 32'hFFFF_FFFF, 4'd2);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      if ((i % 7) == 3)
        drive(($urandom_range(0, 15) == 0), $urandom, s, 1, $urandom, 4'($urandom_range(0, 15)));
      else
        drive_plain(($urandom_range(0, 15) == 0), $urandom, s);
    end

    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: sim_time=%0t limit=100000", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
    end
  end

endmodule
